vga_timing: RTL and testbench

// Raster timing generator for the 640x480@60 VGA output. It divides the
// 100 MHz board clock into a pixel-rate enable and runs the horizontal and

---
 rtl/vga_timing.sv | 131 +++++++++++++
 tb/tb_vga_timing.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// Raster timing generator: divides the board clock down to a pixel-rate
// enable, walks the horizontal/vertical position counters and drives
// registered sync, active-video and coordinate outputs.
// Every porch/sync width is expected to be at least one unit so each
// phase FSM sees a distinct boundary position.
module vga_timing #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int CW      = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          pix_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_FP_START   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_BP_START   = CW'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_FP_START   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SYNC_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_BP_START   = CW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {PH_ACT, PH_FP, PH_SYNC, PH_BP} phase_t;

  // Phase transition for either axis: leave the current phase when the
  // incoming position hits the first coordinate of the following phase.
  function automatic phase_t step_phase(input phase_t cur,
                                        input logic [CW-1:0] pos,
                                        input logic [CW-1:0] fp_start,
                                        input logic [CW-1:0] sync_start,
                                        input logic [CW-1:0] bp_start);
    phase_t nxt;
    nxt = cur;
    case (cur)
      PH_ACT:  if (pos == fp_start)   nxt = PH_FP;
      PH_FP:   if (pos == sync_start) nxt = PH_SYNC;
      PH_SYNC: if (pos == bp_start)   nxt = PH_BP;
      PH_BP:   if (pos == '0)         nxt = PH_ACT;
      default: nxt = PH_ACT;
    endcase
    return nxt;
  endfunction

  logic [DW-1:0] div_reg;
  logic [CW-1:0] h_reg;
  logic [CW-1:0] v_reg;
  phase_t        hph_reg;
  phase_t        vph_reg;

  logic          advance;
  logic [CW-1:0] h_next;
  logic [CW-1:0] v_next;
  phase_t        hph_next;
  phase_t        vph_next;
  logic          act_next;

  // Position one pixel ahead; v only moves when h wraps.
  always_comb begin
    advance  = (div_reg == DIV_LAST);
    h_next   = (h_reg == H_LAST) ? '0 : h_reg + 1'b1;
    v_next   = v_reg;
    if (h_reg == H_LAST) begin
      v_next = (v_reg == V_LAST) ? '0 : v_reg + 1'b1;
    end
    hph_next = step_phase(hph_reg, h_next, H_FP_START, H_SYNC_START, H_BP_START);
    vph_next = step_phase(vph_reg, v_next, V_FP_START, V_SYNC_START, V_BP_START);
    act_next = (hph_next == PH_ACT) && (vph_next == PH_ACT);
  end

  // Divider, counters, phase FSMs and all registered outputs; outputs move
  // together on the advance edge and the start strobes last one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_reg     <= '0;
      h_reg       <= H_LAST;
      v_reg       <= V_LAST;
      hph_reg     <= PH_BP;
      vph_reg     <= PH_BP;
      pix_tick    <= 1'b0;
      active      <= 1'b0;
      x           <= '0;
      y           <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_reg     <= advance ? '0 : div_reg + 1'b1;
      pix_tick    <= advance;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (advance) begin
        h_reg       <= h_next;
        v_reg       <= v_next;
        hph_reg     <= hph_next;
        vph_reg     <= vph_next;
        active      <= act_next;
        x           <= act_next ? h_next : '0;
        y           <= act_next ? v_next : '0;
        hsync       <= (hph_next == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        vsync       <= (vph_next == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        line_start  <= (h_next == '0);
        frame_start <= (h_next == '0) && (v_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: default 640x480 timing for the first pixel
// and line checks, a scaled-down raster for frame-level and mid-frame reset
// checks, and a CLK_DIV=1 raster for the continuous-tick case.
module tb_vga_timing;

  logic clk;
  logic rst0, rst1, rst2;

  // default timing
  logic       pt0, hs0, vs0, ac0, ls0, fs0;
  logic [9:0] x0, y0;
  // scaled: CLK_DIV=2, H 16/4/8/4 (32), V 12/2/2/4 (20)
  logic       pt1, hs1, vs1, ac1, ls1, fs1;
  logic [4:0] x1, y1;
  // CLK_DIV=1, H 8/2/2/2 (14), V 4/1/1/1 (7)
  logic       pt2, hs2, vs2, ac2, ls2, fs2;
  logic [3:0] x2, y2;

  int checks = 0;
  int failures = 0;

  vga_timing dut0 (
    .clk(clk), .reset(rst0), .pix_tick(pt0), .hsync(hs0), .vsync(vs0),
    .active(ac0), .x(x0), .y(y0), .line_start(ls0), .frame_start(fs0)
  );

  vga_timing #(
    .CLK_DIV(2), .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4), .SYNC_POL(1'b0)
  ) dut1 (
    .clk(clk), .reset(rst1), .pix_tick(pt1), .hsync(hs1), .vsync(vs1),
    .active(ac1), .x(x1), .y(y1), .line_start(ls1), .frame_start(fs1)
  );

  vga_timing #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) dut2 (
    .clk(clk), .reset(rst2), .pix_tick(pt2), .hsync(hs2), .vsync(vs2),
    .active(ac2), .x(x2), .y(y2), .line_start(ls2), .frame_start(fs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if ({pt0, ac0, hs0, vs0, ls0, fs0} !== 6'b001100) begin
      failures++;
      $display("FAIL reset_flags got=%b want=001100", {pt0, ac0, hs0, vs0, ls0, fs0});
    end
    checks++;
    if (x0 !== 10'd0 || y0 !== 10'd0) begin
      failures++;
      $display("FAIL reset_xy got x=%0d y=%0d want 0 0", x0, y0);
    end
    $display("reset: flags=%b x=%0d y=%0d", {pt0, ac0, hs0, vs0, ls0, fs0}, x0, y0);
  endtask

  task automatic test_first_pixel;
    rst0 = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      checks++;
      if (pt0 !== 1'b0) begin
        failures++;
        $display("FAIL first_pre_tick edge=%0d got=%b want=0", e, pt0);
      end
    end
    @(negedge clk);
    checks++;
    if ({pt0, ac0, ls0, fs0} !== 4'b1111) begin
      failures++;
      $display("FAIL first_flags got=%b want=1111", {pt0, ac0, ls0, fs0});
    end
    checks++;
    if (x0 !== 10'd0 || y0 !== 10'd0 || hs0 !== 1'b1) begin
      failures++;
      $display("FAIL first_pos got x=%0d y=%0d hs=%b want 0 0 1", x0, y0, hs0);
    end
    $display("first_pixel: flags=%b x=%0d y=%0d", {pt0, ac0, ls0, fs0}, x0, y0);
  endtask

  task automatic test_line;
    int hcnt = 0, lcnt = -1, bad = 0, max_x = 0;
    int falls = 0, fall_h = -1, low_run = 0, last_low = -1;
    int last_ls = -1, ls_period = -1;
    logic exp_act;
    logic prev_hs;
    prev_hs = hs0;
    for (int i = 0; i < 3 * 3200 + 1; i++) begin
      if (i > 0) @(negedge clk);
      if (pt0 !== (i % 4 == 0)) bad++;
      if (vs0 !== 1'b1) bad++;
      if (pt0) begin
        if (ls0) begin hcnt = 0; lcnt++; end else hcnt++;
        exp_act = (hcnt < 640);
        if (ac0 !== exp_act || x0 !== (exp_act ? hcnt : 0) || y0 !== (exp_act ? lcnt : 0)) bad++;
        if (ac0 && int'(x0) > max_x) max_x = int'(x0);
      end
      if (prev_hs && !hs0) begin falls++; fall_h = hcnt; low_run = 0; end
      if (!hs0) low_run++;
      if (!prev_hs && hs0) last_low = low_run;
      if (ls0) begin
        if (last_ls >= 0) ls_period = i - last_ls;
        last_ls = i;
      end
      prev_hs = hs0;
    end
    checks++; if (bad !== 0)        begin failures++; $display("FAIL line_samples bad=%0d want 0", bad); end
    checks++; if (falls !== 3)      begin failures++; $display("FAIL line_hsync_count got=%0d want 3", falls); end
    checks++; if (fall_h !== 656)   begin failures++; $display("FAIL line_hsync_start got=%0d want 656", fall_h); end
    checks++; if (last_low !== 384) begin failures++; $display("FAIL line_hsync_width got=%0d want 384", last_low); end
    checks++; if (ls_period !== 3200) begin failures++; $display("FAIL line_period got=%0d want 3200", ls_period); end
    checks++; if (max_x !== 639)    begin failures++; $display("FAIL line_max_x got=%0d want 639", max_x); end
    $display("line: hs_start=%0d hs_width=%0d period=%0d max_x=%0d bad=%0d",
             fall_h, last_low, ls_period, max_x, bad);
  endtask

  task automatic test_frame;
    int hcnt = 0, vcnt = 0, bad = 0, act_ticks = 0, max_x = 0, max_y = 0;
    int vfalls = 0, vfall_v = -1, vrun = 0, vlow = -1;
    int hfall_h = -1, hrun = 0, hlow = -1;
    int last_fs = -1, fs_period = -1;
    logic exp_act, prev_vs, prev_hs;
    rst1 = 1'b1;
    @(negedge clk);
    checks++;
    if (pt1 !== 1'b0) begin failures++; $display("FAIL frame_pre_tick got=%b want=0", pt1); end
    @(negedge clk);
    checks++;
    if ({pt1, ac1, ls1, fs1} !== 4'b1111) begin
      failures++;
      $display("FAIL frame_first_flags got=%b want=1111", {pt1, ac1, ls1, fs1});
    end
    prev_vs = vs1; prev_hs = hs1;
    for (int i = 0; i < 2 * 1280 + 1; i++) begin
      if (i > 0) @(negedge clk);
      if (pt1 !== (i % 2 == 0)) bad++;
      if (pt1) begin
        if (fs1) begin hcnt = 0; vcnt = 0; end
        else if (ls1) begin hcnt = 0; vcnt++; end
        else hcnt++;
        exp_act = (hcnt < 16) && (vcnt < 12);
        if (ac1 !== exp_act || x1 !== (exp_act ? hcnt : 0) || y1 !== (exp_act ? vcnt : 0)) bad++;
        if (ac1 && i < 1280) act_ticks++;
        if (ac1 && int'(x1) > max_x) max_x = int'(x1);
        if (ac1 && int'(y1) > max_y) max_y = int'(y1);
      end
      if (prev_vs && !vs1) begin vfalls++; vfall_v = vcnt; vrun = 0; end
      if (!vs1) vrun++;
      if (!prev_vs && vs1) vlow = vrun;
      if (prev_hs && !hs1) begin hfall_h = hcnt; hrun = 0; end
      if (!hs1) hrun++;
      if (!prev_hs && hs1) hlow = hrun;
      if (fs1) begin
        if (last_fs >= 0) fs_period = i - last_fs;
        last_fs = i;
      end
      prev_vs = vs1; prev_hs = hs1;
    end
    checks++; if (bad !== 0)         begin failures++; $display("FAIL frame_samples bad=%0d want 0", bad); end
    checks++; if (act_ticks !== 192) begin failures++; $display("FAIL frame_active_ticks got=%0d want 192", act_ticks); end
    checks++; if (max_x !== 15 || max_y !== 11) begin failures++; $display("FAIL frame_max_xy got=%0d,%0d want 15,11", max_x, max_y); end
    checks++; if (vfalls !== 2)      begin failures++; $display("FAIL frame_vsync_count got=%0d want 2", vfalls); end
    checks++; if (vfall_v !== 14)    begin failures++; $display("FAIL frame_vsync_start got=%0d want 14", vfall_v); end
    checks++; if (vlow !== 128)      begin failures++; $display("FAIL frame_vsync_width got=%0d want 128", vlow); end
    checks++; if (hfall_h !== 20 || hlow !== 16) begin failures++; $display("FAIL frame_hsync got start=%0d width=%0d want 20 16", hfall_h, hlow); end
    checks++; if (fs_period !== 1280) begin failures++; $display("FAIL frame_period got=%0d want 1280", fs_period); end
    $display("frame: active_ticks=%0d vs_start=%0d vs_width=%0d period=%0d bad=%0d",
             act_ticks, vfall_v, vlow, fs_period, bad);
  endtask

  task automatic test_reset_mid;
    logic found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (pt1 === 1'b1 && ac1 === 1'b1 && x1 === 5'd5 && y1 === 5'd7) found = 1'b1;
    end
    checks++;
    if (found !== 1'b1) begin failures++; $display("FAIL midreset_reach got=%b want=1 (position 5,7 not seen)", found); end
    rst1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({pt1, ac1, hs1, vs1, ls1, fs1} !== 6'b001100 || x1 !== 5'd0 || y1 !== 5'd0) begin
      failures++;
      $display("FAIL midreset_state got flags=%b x=%0d y=%0d want 001100 0 0",
               {pt1, ac1, hs1, vs1, ls1, fs1}, x1, y1);
    end
    rst1 = 1'b1;
    @(negedge clk);
    checks++;
    if (pt1 !== 1'b0) begin failures++; $display("FAIL midreset_pre_tick got=%b want=0", pt1); end
    @(negedge clk);
    checks++;
    if ({pt1, ac1, ls1, fs1} !== 4'b1111 || x1 !== 5'd0 || y1 !== 5'd0) begin
      failures++;
      $display("FAIL midreset_resume got flags=%b x=%0d y=%0d want 1111 0 0", {pt1, ac1, ls1, fs1}, x1, y1);
    end
    $display("reset_mid: resumed flags=%b x=%0d y=%0d", {pt1, ac1, ls1, fs1}, x1, y1);
  endtask

  task automatic test_div1;
    int hcnt = 0, vcnt = 0, bad = 0;
    int hrun = 0, hlow = -1, hfall_h = -1, last_hf = -1, hper = -1;
    int vrun = 0, vlow = -1, vfall_v = -1, last_fs = -1, fs_period = -1;
    logic exp_act, prev_hs, prev_vs;
    checks++;
    if ({pt2, ac2, hs2, vs2, ls2, fs2} !== 6'b001100) begin
      failures++;
      $display("FAIL div1_reset got=%b want=001100", {pt2, ac2, hs2, vs2, ls2, fs2});
    end
    rst2 = 1'b1;
    @(negedge clk);
    checks++;
    if ({pt2, ac2, ls2, fs2} !== 4'b1111 || x2 !== 4'd0 || y2 !== 4'd0) begin
      failures++;
      $display("FAIL div1_first got flags=%b x=%0d y=%0d want 1111 0 0", {pt2, ac2, ls2, fs2}, x2, y2);
    end
    prev_hs = hs2; prev_vs = vs2;
    for (int i = 0; i < 3 * 98 + 1; i++) begin
      if (i > 0) @(negedge clk);
      if (pt2 !== 1'b1) bad++;
      if (fs2) begin hcnt = 0; vcnt = 0; end
      else if (ls2) begin hcnt = 0; vcnt++; end
      else hcnt++;
      exp_act = (hcnt < 8) && (vcnt < 4);
      if (ac2 !== exp_act || x2 !== (exp_act ? hcnt : 0) || y2 !== (exp_act ? vcnt : 0)) bad++;
      if (prev_hs && !hs2) begin
        hfall_h = hcnt; hrun = 0;
        if (last_hf >= 0) hper = i - last_hf;
        last_hf = i;
      end
      if (!hs2) hrun++;
      if (!prev_hs && hs2) hlow = hrun;
      if (prev_vs && !vs2) begin vfall_v = vcnt; vrun = 0; end
      if (!vs2) vrun++;
      if (!prev_vs && vs2) vlow = vrun;
      if (fs2) begin
        if (last_fs >= 0) fs_period = i - last_fs;
        last_fs = i;
      end
      prev_hs = hs2; prev_vs = vs2;
    end
    checks++; if (bad !== 0)      begin failures++; $display("FAIL div1_samples bad=%0d want 0", bad); end
    checks++; if (hper !== 14)    begin failures++; $display("FAIL div1_hsync_period got=%0d want 14", hper); end
    checks++; if (hlow !== 2 || hfall_h !== 10) begin failures++; $display("FAIL div1_hsync got width=%0d start=%0d want 2 10", hlow, hfall_h); end
    checks++; if (vlow !== 14 || vfall_v !== 5) begin failures++; $display("FAIL div1_vsync got width=%0d start=%0d want 14 5", vlow, vfall_v); end
    checks++; if (fs_period !== 98) begin failures++; $display("FAIL div1_frame_period got=%0d want 98", fs_period); end
    $display("div1: hs_period=%0d hs_width=%0d frame=%0d bad=%0d", hper, hlow, fs_period, bad);
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_line();
    test_frame();
    test_reset_mid();
    test_div1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
